// File: rtl/multicycle_control.sv
// Multi-cycle RV32I controller: sequences fetch/decode/execute/memory/writeback with a memory watchdog.
// Latency 3-5 cycles plus memory waits; stalls in FETCH/MEMORY until ready, ERROR on watchdog expiry.
package multicycle_control_pkg;
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SUBU   = 4'd2,
    ALU_SLL    = 4'd3,
    ALU_SLT    = 4'd4,
    ALU_SLTU   = 4'd5,
    ALU_XOR    = 4'd6,
    ALU_SRL    = 4'd7,
    ALU_SRA    = 4'd8,
    ALU_OR     = 4'd9,
    ALU_AND    = 4'd10,
    ALU_PASS_B = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;
endpackage

module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int INSTRET_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          instr_rdata,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output mem_size_t            dmem_size,
  input  logic                 dmem_ready,
  input  logic                 branch_taken,
  output logic                 ir_en,
  output logic                 pc_en,
  output logic                 pc_sel_target,
  output alu_op_t              alu_op,
  output logic                 alu_src_pc,
  output logic                 alu_src_imm,
  output logic                 rd_we,
  output logic                 wb_sel_mem,
  output logic                 halted,
  output logic                 timeout_err,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic WD_ON = (TIMEOUT_CYCLES != 0);

  state_t          cur, nxt;
  logic [31:0]     ir;
  logic [WD_W-1:0] wd;
  logic            retire;
  logic            wd_expire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load, is_store, is_branch, is_system, is_jump, writes_rd, dec_active;
  alu_op_t    alu_dec;
  mem_size_t  size_dec;

  assign opcode     = ir[6:0];
  assign funct3     = ir[14:12];
  assign is_load    = (opcode == OPC_LOAD);
  assign is_store   = (opcode == OPC_STORE);
  assign is_branch  = (opcode == OPC_BRANCH);
  assign is_system  = (opcode == OPC_SYSTEM);
  assign is_jump    = (opcode == OPC_JAL) || (opcode == OPC_JALR);
  assign writes_rd  = is_load || is_jump || (opcode == OPC_OP) || (opcode == OPC_OP_IMM) ||
                      (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
  assign dec_active = (cur == S_DECODE) || (cur == S_EXECUTE) ||
                      (cur == S_MEMORY) || (cur == S_WRITEBACK);
  assign wd_expire  = WD_ON && (wd == WD_LAST);

  function automatic alu_op_t arith(input logic [2:0] f3, input logic alt, input logic allow_sub);
    case (f3)
      3'd0:    return (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    alu_dec  = ALU_ADD;
    size_dec = MEM_BYTE;
    case (opcode)
      OPC_OP:     alu_dec = arith(funct3, ir[30], 1'b1);
      OPC_OP_IMM: alu_dec = arith(funct3, ir[30], 1'b0);
      OPC_LUI:    alu_dec = ALU_PASS_B;
      OPC_BRANCH: alu_dec = (funct3[2:1] == 2'b11) ? ALU_SUBU : ALU_SUB;
      default:    alu_dec = ALU_ADD;
    endcase
    if (is_load || is_store) begin
      case (funct3[1:0])
        2'b00:   size_dec = MEM_BYTE;
        2'b01:   size_dec = MEM_HALF;
        default: size_dec = MEM_WORD;
      endcase
    end
  end

  // Decoded controls only leave zero while an instruction is in flight.
  always_comb begin
    alu_op      = dec_active ? alu_dec : ALU_ADD;
    dmem_size   = dec_active ? size_dec : MEM_BYTE;
    alu_src_pc  = dec_active && ((opcode == OPC_AUIPC) || is_jump);
    alu_src_imm = dec_active && (is_load || is_store || (opcode == OPC_OP_IMM) ||
                                 (opcode == OPC_AUIPC) || (opcode == OPC_LUI));
  end

  always_comb begin
    nxt           = cur;
    imem_req      = 1'b0;
    ir_en         = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    pc_en         = 1'b0;
    pc_sel_target = 1'b0;
    rd_we         = 1'b0;
    wb_sel_mem    = 1'b0;
    retire        = 1'b0;
    case (cur)
      S_IDLE: if (start) nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en = 1'b1;
          nxt   = S_DECODE;
        end else if (wd_expire) begin
          nxt = S_ERROR;
        end
      end
      S_DECODE: nxt = is_system ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        if (is_load || is_store) begin
          nxt = S_MEMORY;
        end else if (is_branch) begin
          pc_en         = 1'b1;
          pc_sel_target = branch_taken;
          retire        = 1'b1;
          nxt           = S_FETCH;
        end else begin
          nxt = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_en  = 1'b1;
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WRITEBACK;
          end
        end else if (wd_expire) begin
          nxt = S_ERROR;
        end
      end
      S_WRITEBACK: begin
        rd_we         = writes_rd && (ir[11:7] != 5'd0);
        wb_sel_mem    = is_load;
        pc_en         = 1'b1;
        pc_sel_target = is_jump;
        retire        = 1'b1;
        nxt           = S_FETCH;
      end
      S_HALT:  nxt = S_HALT;
      S_ERROR: nxt = S_ERROR;
    endcase
  end

  assign halted      = (cur == S_HALT);
  assign timeout_err = (cur == S_ERROR);
  assign state       = cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur     <= S_IDLE;
      ir      <= '0;
      wd      <= '0;
      instret <= '0;
    end else begin
      cur <= nxt;
      if (ir_en) ir <= instr_rdata;
      if (retire) instret <= instret + INSTRET_W'(1);
      // Watchdog restarts on every state entry and only runs while stalled on a memory.
      if ((nxt != cur) || !((cur == S_FETCH) || (cur == S_MEMORY))) wd <= '0;
      else wd <= wd + WD_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: table of instructions with expected controls,
// retire-time comparison, plus reset, halt, watchdog and watchdog-disabled scenarios.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, imem_ready, dmem_ready, branch_taken;
  logic [31:0] instr_rdata;
  logic        imem_req, dmem_req, dmem_we, ir_en, pc_en, pc_sel_target;
  logic        alu_src_pc, alu_src_imm, rd_we, wb_sel_mem, halted, timeout_err;
  mem_size_t   dmem_size;
  alu_op_t     alu_op;
  logic [2:0]  state;
  logic [3:0]  instret;

  logic        rst2_n, start2, imem_ready2;
  logic        imem_req2, dmem_req2, dmem_we2, ir_en2, pc_en2, pc_sel_target2;
  logic        alu_src_pc2, alu_src_imm2, rd_we2, wb_sel_mem2, halted2, timeout_err2;
  mem_size_t   dmem_size2;
  alu_op_t     alu_op2;
  logic [2:0]  state2;
  logic [31:0] instret2;

  multicycle_control #(.TIMEOUT_CYCLES(4), .INSTRET_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_rdata(instr_rdata),
    .imem_req(imem_req), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_size(dmem_size), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .ir_en(ir_en), .pc_en(pc_en), .pc_sel_target(pc_sel_target), .alu_op(alu_op),
    .alu_src_pc(alu_src_pc), .alu_src_imm(alu_src_imm), .rd_we(rd_we), .wb_sel_mem(wb_sel_mem),
    .halted(halted), .timeout_err(timeout_err), .state(state), .instret(instret)
  );

  multicycle_control #(.TIMEOUT_CYCLES(0)) dut_nowd (
    .clk(clk), .rst_n(rst2_n), .start(start2), .instr_rdata(32'h0),
    .imem_req(imem_req2), .imem_ready(imem_ready2), .dmem_req(dmem_req2), .dmem_we(dmem_we2),
    .dmem_size(dmem_size2), .dmem_ready(1'b0), .branch_taken(1'b0),
    .ir_en(ir_en2), .pc_en(pc_en2), .pc_sel_target(pc_sel_target2), .alu_op(alu_op2),
    .alu_src_pc(alu_src_pc2), .alu_src_imm(alu_src_imm2), .rd_we(rd_we2), .wb_sel_mem(wb_sel_mem2),
    .halted(halted2), .timeout_err(timeout_err2), .state(state2), .instret(instret2)
  );

  logic [20:0] outs;
  assign outs = {imem_req, dmem_req, dmem_we, dmem_size, ir_en, pc_en, pc_sel_target, alu_op,
                 alu_src_pc, alu_src_imm, rd_we, wb_sel_mem, halted, timeout_err, state};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    int          iw;
    int          dw;
    logic        tk;
    int          base;
    logic        rdwe;
    logic        psel;
    logic        wbm;
    alu_op_t     aop;
    logic        spc;
    logic        simm;
    logic        dwe;
    mem_size_t   dsz;
    logic        mem;
  } row_t;

  row_t tbl[$];
  row_t expq[$];

  task automatic add(input logic [31:0] ins, input int iw, input int dw, input logic tk,
                     input int base, input logic rdwe, input logic psel, input logic wbm,
                     input alu_op_t aop, input logic spc, input logic simm, input logic dwe,
                     input mem_size_t dsz, input logic mem);
    row_t r;
    r.ins = ins; r.iw = iw; r.dw = dw; r.tk = tk; r.base = base; r.rdwe = rdwe; r.psel = psel;
    r.wbm = wbm; r.aop = aop; r.spc = spc; r.simm = simm; r.dwe = dwe; r.dsz = dsz; r.mem = mem;
    tbl.push_back(r);
  endtask

  // Per-instruction observations gathered between retires.
  int         cyc, nrd, nreq;
  logic       seen_wbm, seen_dwe, fetch_nz, dec_spc, dec_simm;
  mem_size_t  seen_dsz;
  alu_op_t    dec_aop;
  logic [3:0] exp_ir;

  task automatic mon_clear;
    cyc = 0; nrd = 0; nreq = 0;
    seen_wbm = 1'b0; seen_dwe = 1'b0; fetch_nz = 1'b0;
    dec_spc = 1'b0; dec_simm = 1'b0; seen_dsz = MEM_BYTE; dec_aop = ALU_ADD;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_clear();
      exp_ir = 4'd0;
    end else if (state inside {[3'd1:3'd5]}) begin
      row_t e;
      cyc++;
      if (rd_we) nrd++;
      if (dmem_req) begin
        nreq++;
        seen_dwe = dmem_we;
        seen_dsz = dmem_size;
      end
      if (state == 3'd5) seen_wbm = wb_sel_mem;
      if (state == 3'd2) begin
        dec_aop = alu_op; dec_spc = alu_src_pc; dec_simm = alu_src_imm;
      end
      if (state == 3'd1 && ({alu_op, alu_src_pc, alu_src_imm, dmem_size} != 8'd0)) fetch_nz = 1'b1;
      if (pc_en) begin
        check("retire_pending", 32'(expq.size()), 32'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("latency", 32'(cyc), 32'(e.base + e.iw + (e.mem ? e.dw : 0)));
          check("rd_we_at_retire", 32'(rd_we), 32'(e.rdwe));
          check("rd_we_cycles", 32'(nrd), e.rdwe ? 32'd1 : 32'd0);
          check("pc_sel_target", 32'(pc_sel_target), 32'(e.psel));
          check("wb_sel_mem", 32'(seen_wbm), 32'(e.wbm));
          check("alu_op_retire", 32'(alu_op), 32'(e.aop));
          check("alu_op_decode", 32'(dec_aop), 32'(e.aop));
          check("alu_src_pc", 32'(dec_spc), 32'(e.spc));
          check("alu_src_imm", 32'(dec_simm), 32'(e.simm));
          check("dmem_req_cycles", 32'(nreq), e.mem ? 32'(e.dw + 1) : 32'd0);
          check("dmem_we", 32'(seen_dwe), 32'(e.dwe));
          check("dmem_size", 32'(seen_dsz), e.mem ? 32'(e.dsz) : 32'd0);
          check("fetch_dec_zero", 32'(fetch_nz), 32'd0);
        end
        check("instret", 32'(instret), 32'(exp_ir));
        exp_ir++;
        mon_clear();
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    expq.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic do_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Entered on the first FETCH cycle; returns on the first FETCH cycle of the next instruction.
  task automatic run(input row_t r);
    logic done;
    done = 1'b0;
    expq.push_back(r);
    instr_rdata  = r.ins;
    branch_taken = r.tk;
    imem_ready   = 1'b0;
    repeat (r.iw) step();
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    for (int g = 0; g < 64; g++) begin
      if (state == 3'd1 || state == 3'd0 || state >= 3'd6) begin
        done = 1'b1;
        break;
      end
      if (state == 3'd4) begin
        dmem_ready = 1'b0;
        repeat (r.dw) step();
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
      end else begin
        step();
      end
    end
    check("run_done", 32'(done), 32'd1);
    check("back_in_fetch", 32'(state), 32'd1);
    check("retired", 32'(expq.size()), 32'd0);
  endtask

  task automatic fetch_lw_to_memory;
    instr_rdata = 32'h0000A103;
    imem_ready  = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    step();
    check("in_memory", 32'(state), 32'd4);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; rst2_n = 1'b0; start = 1'b0; start2 = 1'b0;
    imem_ready = 1'b0; imem_ready2 = 1'b0; dmem_ready = 1'b0;
    instr_rdata = 32'h0; branch_taken = 1'b0;
    step();
    step();
    rst_n = 1'b1; rst2_n = 1'b1;
    check("reset_outs", 32'(outs), 32'd0);
    check("reset_instret", 32'(instret), 32'd0);
    check("reset_state_nowd", 32'(state2), 32'd0);

    start2 = 1'b1;
    do_start();
    start2 = 1'b0;
    check("start_to_fetch", 32'(state), 32'd1);

    //   instr        iw dw tk base rdwe psel wbm aop         spc simm dwe size      mem
    add(32'h00500093, 0, 0, 0, 4, 1, 0, 0, ALU_ADD,    0, 1, 0, MEM_BYTE, 0); // addi x1,x0,5
    add(32'h0000A103, 0, 3, 0, 5, 1, 0, 1, ALU_ADD,    0, 1, 0, MEM_WORD, 1); // lw
    add(32'h00000463, 0, 0, 1, 3, 0, 1, 0, ALU_SUB,    0, 0, 0, MEM_BYTE, 0); // beq taken
    add(32'h00009463, 0, 0, 0, 3, 0, 0, 0, ALU_SUB,    0, 0, 0, MEM_BYTE, 0); // bne not taken
    add(32'h0020E463, 2, 0, 1, 3, 0, 1, 0, ALU_SUBU,   0, 0, 0, MEM_BYTE, 0); // bltu
    add(32'h002081A3, 0, 1, 0, 4, 0, 0, 0, ALU_ADD,    0, 1, 1, MEM_BYTE, 1); // sb
    add(32'h0020A023, 1, 0, 0, 4, 0, 0, 0, ALU_ADD,    0, 1, 1, MEM_WORD, 1); // sw
    add(32'h002081B3, 0, 0, 0, 4, 1, 0, 0, ALU_ADD,    0, 0, 0, MEM_BYTE, 0); // add
    add(32'h402081B3, 0, 0, 0, 4, 1, 0, 0, ALU_SUB,    0, 0, 0, MEM_BYTE, 0); // sub
    add(32'h4020D1B3, 0, 0, 0, 4, 1, 0, 0, ALU_SRA,    0, 0, 0, MEM_BYTE, 0); // sra
    add(32'h0020F1B3, 0, 0, 0, 4, 1, 0, 0, ALU_AND,    0, 0, 0, MEM_BYTE, 0); // and
    add(32'h4030D213, 0, 0, 0, 4, 1, 0, 0, ALU_SRA,    0, 1, 0, MEM_BYTE, 0); // srai
    add(32'h40008293, 0, 0, 0, 4, 1, 0, 0, ALU_ADD,    0, 1, 0, MEM_BYTE, 0); // addi, bit30 set
    add(32'h12345337, 0, 0, 0, 4, 1, 0, 0, ALU_PASS_B, 0, 1, 0, MEM_BYTE, 0); // lui
    add(32'h00001397, 0, 0, 0, 4, 1, 0, 0, ALU_ADD,    1, 1, 0, MEM_BYTE, 0); // auipc
    add(32'h008000EF, 0, 0, 0, 4, 1, 1, 0, ALU_ADD,    1, 0, 0, MEM_BYTE, 0); // jal x1
    add(32'h00008067, 0, 0, 0, 4, 0, 1, 0, ALU_ADD,    1, 0, 0, MEM_BYTE, 0); // jalr x0
    add(32'h00000013, 0, 0, 0, 4, 0, 0, 0, ALU_ADD,    0, 1, 0, MEM_BYTE, 0); // nop, rd=x0
    add(32'h00000FFF, 0, 0, 0, 4, 0, 0, 0, ALU_ADD,    0, 0, 0, MEM_BYTE, 0); // unknown opcode
    add(32'h0010B093, 3, 0, 0, 4, 1, 0, 0, ALU_SLTU,   0, 1, 0, MEM_BYTE, 0); // sltiu, ready at threshold
    add(32'h00009103, 0, 2, 0, 5, 1, 0, 1, ALU_ADD,    0, 1, 0, MEM_HALF, 1); // lh
    for (int i = 0; i < 8; i++)
      add(32'h00500093, int'($urandom_range(0, 3)), 0, 0, 4, 1, 0, 0, ALU_ADD, 0, 1, 0, MEM_BYTE, 0);
    foreach (tbl[i]) run(tbl[i]);

    // Reset in the middle of a load abandons it without retiring.
    fetch_lw_to_memory();
    step();
    do_reset();
    check("midreset_outs", 32'(outs), 32'd0);
    check("midreset_instret", 32'(instret), 32'd0);
    step();
    check("idle_holds", 32'(state), 32'd0);
    do_start();
    check("restart_fetch", 32'(state), 32'd1);
    run(tbl[0]);

    // Store, then ECALL halts; later start pulses change nothing.
    do_reset();
    do_start();
    run(tbl[5]);
    instr_rdata = 32'h00000073;
    imem_ready  = 1'b1;
    step();
    imem_ready = 1'b0;
    check("ecall_decode", 32'(state), 32'd2);
    step();
    check("ecall_halt_state", 32'(state), 32'd6);
    check("ecall_halted", 32'(halted), 32'd1);
    check("ecall_instret", 32'(instret), 32'd1);
    check("halt_ctrl_zero", 32'({alu_op, alu_src_pc, alu_src_imm, dmem_size, pc_en, rd_we}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      step();
    end
    check("halt_absorbing", 32'(state), 32'd6);
    check("halt_instret", 32'(instret), 32'd1);

    // Watchdog in FETCH: four stalled cycles then ERROR, which is sticky.
    do_reset();
    do_start();
    n = 0;
    while (state == 3'd1 && n < 50) begin
      n++;
      step();
    end
    check("fetch_wait_cycles", 32'(n), 32'd4);
    check("fetch_timeout_state", 32'(state), 32'd7);
    check("fetch_timeout_err", 32'(timeout_err), 32'd1);
    imem_ready = 1'b1;
    start = 1'b1;
    repeat (3) step();
    imem_ready = 1'b0;
    start = 1'b0;
    check("error_sticky", 32'(timeout_err), 32'd1);
    check("error_absorbing", 32'(state), 32'd7);

    // Watchdog in MEMORY.
    do_reset();
    do_start();
    fetch_lw_to_memory();
    n = 0;
    while (state == 3'd4 && n < 50) begin
      n++;
      step();
    end
    check("mem_wait_cycles", 32'(n), 32'd4);
    check("mem_timeout_err", 32'(timeout_err), 32'd1);
    check("mem_timeout_no_retire", 32'(instret), 32'd0);

    // With the watchdog disabled the second controller is still waiting in FETCH.
    check("nowd_state", 32'(state2), 32'd1);
    check("nowd_imem_req", 32'(imem_req2), 32'd1);
    check("nowd_no_error", 32'(timeout_err2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle controller for the next-generation RV32I core. It replaces the single-cycle combinational decode with an FSM that sequences each instruction through fetch, decode, execute, memory and writeback, and handshakes with instruction and data memories that may take several cycles to respond. It drives the existing datapath enables: PC, instruction register, register file, ALU source muxes and writeback mux. It adds a memory timeout watchdog and a retired-instruction counter.

## Interface
- TIMEOUT_CYCLES, 16, maximum wait cycles in FETCH or MEMORY before entering ERROR; 0 disables the watchdog
- INSTRET_W, 32, width of the retired-instruction counter
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset; one clock, sampled on rising edge
- start  in  1  leave IDLE and begin fetching
- instr_rdata  in  32  instruction word, valid when imem_ready=1
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch complete this cycle
- dmem_req  out  1  data access request
- dmem_we  out  1  data write (store)
- dmem_size  out  mem_size_t  access size, from funct3
- dmem_ready  in  1  data access complete this cycle
- branch_taken  in  1  branch comparison result from the datapath, valid in EXECUTE
- ir_en  out  1  latch instr_rdata into the datapath IR
- pc_en  out  1  update PC this cycle
- pc_sel_target  out  1  1 = branch/jump target, 0 = PC+4
- alu_op  out  alu_op_t  ALU operation
- alu_src_pc  out  1  ALU A = PC (AUIPC, JAL, JALR)
- alu_src_imm  out  1  ALU B = immediate (LOAD, STORE, OP_IMM, AUIPC, LUI)
- rd_we  out  1  register file write
- wb_sel_mem  out  1  writeback from memory (loads)
- halted  out  1  in HALT
- timeout_err  out  1  in ERROR; sticky until reset
- state  out  3  current state code, for debug
- instret  out  INSTRET_W  retired-instruction count

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, ERROR=7.
- IDLE: on start=1, go to FETCH. start is ignored in every other state.
- FETCH: imem_req=1.
  - On imem_ready=1: pulse ir_en, capture instr_rdata into an internal copy, go to DECODE.
- DECODE: lasts one cycle.
  - Opcode SYSTEM: go to HALT; not counted in instret.
  - Any other opcode: go to EXECUTE.
- EXECUTE: lasts one cycle.
  - LOAD or STORE: go to MEMORY.
  - BRANCH: pc_en=1 and pc_sel_target=branch_taken; retire; go to FETCH.
  - All other opcodes: go to WRITEBACK.
- MEMORY: dmem_req=1; dmem_we=1 for STORE; hold until dmem_ready=1.
  - STORE: pc_en=1 (PC+4), retire, go to FETCH.
  - LOAD: go to WRITEBACK.
- WRITEBACK:
  - rd_we=1 for LOAD, OP, OP_IMM, LUI, AUIPC, JAL, JALR, and only when rd≠0.
  - wb_sel_mem=1 for LOAD.
  - pc_en=1; pc_sel_target=1 for JAL and JALR.
  - Retire, then go to FETCH.
- Decoded outputs (alu_op, alu_src_*, dmem_size): derived from the internal instruction copy; valid from DECODE until the instruction retires; 0 in IDLE, FETCH, HALT and ERROR.
- alu_op mapping: unchanged from the current single-cycle core.
  - OP SUB and SRA use funct7 alt.
  - OP_IMM never produces SUB.
  - LUI = PASS_B.
  - Signed branches = SUB; unsigned branches = SUBU.
  - Everything else = ADD.
- Retire: instret increments by 1 and wraps modulo 2^INSTRET_W.
- Unknown opcode: treated as a no-op. Passes through WRITEBACK with rd_we=0, advances PC+4, retires.
- Watchdog: counts consecutive cycles spent in FETCH or MEMORY with ready=0, and clears on state entry. When the count reaches TIMEOUT_CYCLES, go to ERROR. If ready=1 arrives in the threshold cycle, ready wins.
- HALT and ERROR are absorbing states; only reset exits them.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, watchdog=0, instret=0, instruction copy=0, all outputs 0. Reset mid-instruction abandons it with no retire.
- imem_req and dmem_req are Moore outputs of the state. Ready is sampled at the rising edge.
- Minimum latency in cycles, with zero memory wait:
  - ALU, LUI, AUIPC, JAL, JALR: 4
  - LOAD: 5
  - STORE: 4
  - BRANCH: 3
  - SYSTEM: FETCH, DECODE, then HALT
- Each wait cycle adds 1 cycle to the latency.
- pc_en, rd_we and the instret increment occur in the same single cycle, the last cycle of the instruction.

## Test plan
- ADDI x1,x0,5 with imem_ready tied high → states 1,2,3,5,1; rd_we=1 for 1 cycle; instret 0→1 after 4 cycles.
- LW with dmem_ready delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, dmem_size=MEM_WORD, wb_sel_mem=1 in WRITEBACK; total 8 cycles.
- BEQ with branch_taken=1, then BNE with branch_taken=0 → pc_sel_target 1 then 0, each with a one-cycle pc_en in EXECUTE; 3 cycles each; rd_we never asserted.
- SB then ECALL → dmem_we=1 with MEM_BYTE; then halted=1 after DECODE; instret=1; start pulses afterwards ignored.
- TIMEOUT_CYCLES=4 with imem_ready held low → timeout_err=1 on entry to ERROR after 4 FETCH cycles. With TIMEOUT_CYCLES=0 the controller waits indefinitely.
- Reset asserted during MEMORY, then start again → outputs 0 and instret=0 while in IDLE; the next instruction begins in FETCH.
